// File: rtl/i2c_cmd_sequencer_if.sv
// Bundle of the push, I2C-master and result channels of i2c_cmd_sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface i2c_cmd_sequencer_if;
  logic       push_valid;
  logic       push_ready;
  logic       push_rw;
  logic [6:0] push_addr;
  logic [7:0] push_data;
  logic [2:0] m_cmd;
  logic [7:0] m_inp;
  logic       m_busy;
  logic       m_stat;
  logic [7:0] m_out;
  logic       res_valid;
  logic       res_rw;
  logic       res_ack;
  logic [7:0] res_data;
  logic       res_timeout;

  modport slave (
    input  push_valid, push_rw, push_addr, push_data, m_busy, m_stat, m_out,
    output push_ready, m_cmd, m_inp, res_valid, res_rw, res_ack, res_data, res_timeout
  );

  modport master (
    output push_valid, push_rw, push_addr, push_data, m_busy, m_stat, m_out,
    input  push_ready, m_cmd, m_inp, res_valid, res_rw, res_ack, res_data, res_timeout
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Queues {rw, addr, data} transactions and replays each to the I2C master as ADDR/DATA/GO,
// then reports one result per transaction. Optional wait-phase watchdog: I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  i2c_cmd_sequencer_if.slave     bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LEVEL_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO   = AW'(0);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_ADDR  = 3'd1;
  localparam logic [2:0] CMD_DATA  = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_WRITE = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_GO    = 3'd3,
    W_START = 3'd4,
    W_DONE  = 3'd5,
    REPORT  = 3'd6
  } state_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("i2c_cmd_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  state_t        state, state_next;
  logic          rw_mem   [DEPTH];
  logic [6:0]    addr_mem [DEPTH];
  logic [7:0]    data_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_next;
  logic          push_fire, pop;
  logic          cur_rw;
  logic [7:0]    cur_data;
  logic [2:0]    cmd_next;
  logic [7:0]    inp_next;
  logic          res_load, ack_next, to_next;
  logic [7:0]    rdata_next;
  logic          expired;

  assign push_fire = bus.push_valid & bus.push_ready;
  assign pop       = (state == IDLE) && (level != LEVEL_ZERO);

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);
  logic [TW-1:0] tcnt;

  // Wait-phase watchdog: restarts on every state change, saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= {TW{1'b0}};
    end else if (state_next != state) begin
      tcnt <= {TW{1'b0}};
    end else if (tcnt != TLIM) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign expired = (tcnt == TLIM);
`else
  assign expired = 1'b0;
`endif

  // Occupancy after this cycle's push/pop.
  always_comb begin
    level_next = level;
    case ({push_fire, pop})
      2'b10:   level_next = level + LEVEL_ONE;
      2'b01:   level_next = level - LEVEL_ONE;
      default: level_next = level;
    endcase
  end

  // FIFO storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      rw_mem[wr_ptr]   <= bus.push_rw;
      addr_mem[wr_ptr] <= bus.push_addr;
      data_mem[wr_ptr] <= bus.push_data;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= PTR_ZERO;
      rd_ptr         <= PTR_ZERO;
      level          <= LEVEL_ZERO;
      bus.push_ready <= 1'b1;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)       rd_ptr <= rd_ptr + PTR_ONE;
      level          <= level_next;
      bus.push_ready <= (level_next != LEVEL_FULL);
    end
  end

  // Next state plus the values the output registers take on entering it.
  always_comb begin
    state_next = state;
    cmd_next   = CMD_NONE;
    inp_next   = 8'd0;
    res_load   = 1'b0;
    ack_next   = 1'b0;
    rdata_next = 8'd0;
    to_next    = 1'b0;
    case (state)
      IDLE: begin
        if (level != LEVEL_ZERO) begin
          state_next = S_ADDR;
          cmd_next   = CMD_ADDR;
          inp_next   = {1'b0, addr_mem[rd_ptr]};
        end else begin
          state_next = IDLE;
        end
      end
      S_ADDR: begin
        state_next = S_DATA;
        cmd_next   = CMD_DATA;
        inp_next   = cur_data;
      end
      S_DATA: begin
        state_next = S_GO;
        cmd_next   = cur_rw ? CMD_READ : CMD_WRITE;
      end
      S_GO: state_next = W_START;
      W_START: begin
        if (bus.m_busy) begin
          state_next = W_DONE;
        end else if (expired) begin
          state_next = REPORT;
          res_load   = 1'b1;
          to_next    = 1'b1;
        end else begin
          state_next = W_START;
        end
      end
      W_DONE: begin
        if (!bus.m_busy) begin
          state_next = REPORT;
          res_load   = 1'b1;
          ack_next   = bus.m_stat;
          rdata_next = cur_rw ? bus.m_out : 8'd0;
        end else if (expired) begin
          state_next = REPORT;
          res_load   = 1'b1;
          to_next    = 1'b1;
        end else begin
          state_next = W_DONE;
        end
      end
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, working copy of the popped entry and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cur_rw          <= 1'b0;
      cur_data        <= 8'd0;
      bus.m_cmd       <= CMD_NONE;
      bus.m_inp       <= 8'd0;
      bus.res_valid   <= 1'b0;
      bus.res_rw      <= 1'b0;
      bus.res_ack     <= 1'b0;
      bus.res_data    <= 8'd0;
      bus.res_timeout <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state         <= state_next;
      bus.m_cmd     <= cmd_next;
      bus.m_inp     <= inp_next;
      bus.res_valid <= (state_next == REPORT);
      busy          <= (state_next != IDLE);
      if (pop) begin
        cur_rw   <= rw_mem[rd_ptr];
        cur_data <= data_mem[rd_ptr];
      end
      if (res_load) begin
        bus.res_rw      <= cur_rw;
        bus.res_ack     <= ack_next;
        bus.res_data    <= rdata_next;
        bus.res_timeout <= to_next;
      end
    end
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed self-checking bench for i2c_cmd_sequencer; the bench plays the I2C master.
// The watchdog scenario runs only when I2C_SEQ_TIMEOUT_EN is defined.
module tb_i2c_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] level;
  int ntests = 0;
  int nfail  = 0;

  i2c_cmd_sequencer_if bus();

  i2c_cmd_sequencer #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .level (level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic push_one(input logic rw, input logic [6:0] a, input logic [7:0] d);
    int  n = 0;
    bit  acc = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_rw    = rw;
    bus.push_addr  = a;
    bus.push_data  = d;
    while (!acc && n < 50) begin
      acc = bus.push_ready;
      @(negedge clk);
      n++;
    end
    bus.push_valid = 1'b0;
    ntests++;
    if (!acc) begin nfail++; $display("FAIL push_accept: addr %0h never accepted", a); end
  endtask

  task automatic expect_issue(input logic rw, input logic [6:0] a, input logic [7:0] d,
                              input int max_wait, input string name);
    int n = 0;
    logic [2:0] go;
    go = rw ? 3'd3 : 3'd4;
    while (bus.m_cmd !== 3'd1 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    ntests++;
    if (bus.m_cmd !== 3'd1) begin
      nfail++; $display("FAIL %s_addr_cmd: got %0d, expected 1 within %0d cycles", name, bus.m_cmd, max_wait);
      return;
    end
    ntests++;
    if (bus.m_inp !== {1'b0, a}) begin nfail++; $display("FAIL %s_addr_inp: got %0h, expected %0h", name, bus.m_inp, {1'b0, a}); end
    @(negedge clk);
    ntests++;
    if (bus.m_cmd !== 3'd2 || bus.m_inp !== d) begin
      nfail++; $display("FAIL %s_data: got cmd %0d inp %0h, expected 2 %0h", name, bus.m_cmd, bus.m_inp, d);
    end
    @(negedge clk);
    ntests++;
    if (bus.m_cmd !== go || bus.m_inp !== 8'd0) begin
      nfail++; $display("FAIL %s_go: got cmd %0d inp %0h, expected %0d 0", name, bus.m_cmd, bus.m_inp, go);
    end
  endtask

  task automatic complete(input bit stat, input logic [7:0] outv, input int blen,
                          input logic exp_rw, input logic exp_ack, input logic [7:0] exp_data,
                          input string name);
    int n = 0;
    bus.m_busy = 1'b1;
    repeat (blen) @(negedge clk);
    bus.m_stat = stat;
    bus.m_out  = outv;
    bus.m_busy = 1'b0;
    while (bus.res_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    ntests++;
    if (bus.res_valid !== 1'b1) begin
      nfail++; $display("FAIL %s_res_valid: no result pulse within 10 cycles", name);
      return;
    end
    ntests++;
    if (bus.res_rw !== exp_rw || bus.res_ack !== exp_ack || bus.res_data !== exp_data || bus.res_timeout !== 1'b0) begin
      nfail++;
      $display("FAIL %s_result: got rw %0b ack %0b data %0h to %0b, expected %0b %0b %0h 0",
               name, bus.res_rw, bus.res_ack, bus.res_data, bus.res_timeout, exp_rw, exp_ack, exp_data);
    end
    @(negedge clk);
    ntests++;
    if (bus.res_valid !== 1'b0 || bus.res_ack !== exp_ack || bus.res_data !== exp_data) begin
      nfail++;
      $display("FAIL %s_hold: got valid %0b ack %0b data %0h, expected 0 %0b %0h",
               name, bus.res_valid, bus.res_ack, bus.res_data, exp_ack, exp_data);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    ntests++;
    if (bus.push_ready !== 1'b1 || level !== 3'd0 || busy !== 1'b0 || bus.m_cmd !== 3'd0 || bus.m_inp !== 8'd0) begin
      nfail++;
      $display("FAIL reset_ctrl: got ready %0b level %0d busy %0b cmd %0d inp %0h, expected 1 0 0 0 0",
               bus.push_ready, level, busy, bus.m_cmd, bus.m_inp);
    end
    ntests++;
    if (bus.res_valid !== 1'b0 || bus.res_rw !== 1'b0 || bus.res_ack !== 1'b0 || bus.res_data !== 8'd0 || bus.res_timeout !== 1'b0) begin
      nfail++;
      $display("FAIL reset_res: got valid %0b rw %0b ack %0b data %0h to %0b, expected all 0",
               bus.res_valid, bus.res_rw, bus.res_ack, bus.res_data, bus.res_timeout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    push_one(1'b0, 7'h50, 8'hA5);
    ntests++;
    if (level !== 3'd1 || bus.m_cmd !== 3'd0 || busy !== 1'b0) begin
      nfail++; $display("FAIL write_post_push: got level %0d cmd %0d busy %0b, expected 1 0 0", level, bus.m_cmd, busy);
    end
    expect_issue(1'b0, 7'h50, 8'hA5, 1, "write");
    ntests++;
    if (busy !== 1'b1 || level !== 3'd0) begin
      nfail++; $display("FAIL write_busy: got busy %0b level %0d, expected 1 0", busy, level);
    end
    complete(1'b1, 8'hFF, 20, 1'b0, 1'b1, 8'h00, "write");
  endtask

  task automatic test_read();
    push_one(1'b1, 7'h3C, 8'h00);
    expect_issue(1'b1, 7'h3C, 8'h00, 1, "read");
    complete(1'b1, 8'h5A, 20, 1'b1, 1'b1, 8'h5A, "read");
  endtask

  task automatic test_nack();
    push_one(1'b0, 7'h21, 8'h33);
    expect_issue(1'b0, 7'h21, 8'h33, 1, "nack");
    complete(1'b0, 8'h77, 5, 1'b0, 1'b0, 8'h00, "nack");
  endtask

  task automatic test_full();
    logic [6:0] a;
    logic [7:0] d, o;
    logic       rw, st;
    for (int i = 0; i < 5; i++) begin
      a  = 7'h10 + 7'(i);
      d  = 8'h80 + 8'(i);
      rw = (i % 2) == 1;
      push_one(rw, a, d);
    end
    ntests++;
    if (level !== 3'd4 || bus.push_ready !== 1'b0 || busy !== 1'b1) begin
      nfail++; $display("FAIL full_state: got level %0d ready %0b busy %0b, expected 4 0 1", level, bus.push_ready, busy);
    end
    bus.push_valid = 1'b1;
    bus.push_addr  = 7'h7F;
    repeat (3) @(negedge clk);
    bus.push_valid = 1'b0;
    ntests++;
    if (level !== 3'd4 || bus.push_ready !== 1'b0) begin
      nfail++; $display("FAIL full_reject: got level %0d ready %0b, expected 4 0", level, bus.push_ready);
    end
    repeat (10) @(negedge clk);
    ntests++;
    if (bus.m_cmd !== 3'd0 || busy !== 1'b1) begin
      nfail++; $display("FAIL full_stall: got cmd %0d busy %0b, expected 0 1", bus.m_cmd, busy);
    end
    for (int i = 0; i < 5; i++) begin
      a  = 7'h10 + 7'(i);
      d  = 8'h80 + 8'(i);
      o  = 8'hC0 + 8'(i);
      rw = (i % 2) == 1;
      st = (i != 3);
      if (i > 0) expect_issue(rw, a, d, 1, $sformatf("full%0d", i));
      complete(st, o, 3, rw, st, rw ? o : 8'h00, $sformatf("full%0d", i));
    end
    ntests++;
    if (level !== 3'd0 || bus.push_ready !== 1'b1 || busy !== 1'b0) begin
      nfail++; $display("FAIL full_drain: got level %0d ready %0b busy %0b, expected 0 1 0", level, bus.push_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    push_one(1'b0, 7'h11, 8'h22);
    push_one(1'b1, 7'h12, 8'h00);
    expect_issue(1'b0, 7'h11, 8'h22, 1, "rstmid");
    bus.m_busy = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    ntests++;
    if (bus.m_cmd !== 3'd0 || level !== 3'd0 || busy !== 1'b0 || bus.push_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      nfail++;
      $display("FAIL rstmid_state: got cmd %0d level %0d busy %0b ready %0b valid %0b, expected 0 0 0 1 0",
               bus.m_cmd, level, busy, bus.push_ready, bus.res_valid);
    end
    @(negedge clk);
    bus.m_busy = 1'b0;
    bus.m_stat = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.m_cmd !== 3'd0 || level !== 3'd0) seen = 1'b1;
    end
    ntests++;
    if (seen) begin nfail++; $display("FAIL rstmid_quiet: got activity after reset, expected none"); end
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    push_one(1'b0, 7'h40, 8'h01);
    push_one(1'b0, 7'h41, 8'h02);
    expect_issue(1'b0, 7'h40, 8'h01, 1, "timeout");
    while (bus.res_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ntests++;
    if (n !== 17) begin nfail++; $display("FAIL timeout_latency: got %0d cycles after GO, expected 17", n); end
    ntests++;
    if (bus.res_timeout !== 1'b1 || bus.res_ack !== 1'b0 || bus.res_data !== 8'h00) begin
      nfail++; $display("FAIL timeout_result: got to %0b ack %0b data %0h, expected 1 0 0", bus.res_timeout, bus.res_ack, bus.res_data);
    end
    @(negedge clk);
    expect_issue(1'b0, 7'h41, 8'h02, 1, "after_timeout");
    complete(1'b1, 8'h00, 4, 1'b0, 1'b1, 8'h00, "after_timeout");
  endtask
`endif

  initial begin
    bus.push_valid = 1'b0;
    bus.push_rw    = 1'b0;
    bus.push_addr  = 7'h00;
    bus.push_data  = 8'h00;
    bus.m_busy     = 1'b0;
    bus.m_stat     = 1'b0;
    bus.m_out      = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_full();
    test_reset_mid();
`ifdef I2C_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
